// File: rtl/jump_controller_pkg.sv
// Shared definitions for the jump controller: condition codes, FSM encoding, condition evaluation.
package jump_controller_pkg;

    localparam int unsigned COND_W = 3;

    localparam logic [COND_W-1:0] COND_ALWAYS = 3'b000;
    localparam logic [COND_W-1:0] COND_Z      = 3'b001;
    localparam logic [COND_W-1:0] COND_NZ     = 3'b010;
    localparam logic [COND_W-1:0] COND_C      = 3'b011;
    localparam logic [COND_W-1:0] COND_NC     = 3'b100;
    localparam logic [COND_W-1:0] COND_N      = 3'b101;
    localparam logic [COND_W-1:0] COND_NN     = 3'b110;
    localparam logic [COND_W-1:0] COND_P      = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EVAL = 2'b01,
        DONE = 2'b10
    } state_e;

    // True when the flag set satisfies the condition code.
    function automatic logic cond_met(input logic [COND_W-1:0] cond,
                                      input logic c, input logic n,
                                      input logic z, input logic p);
        logic r;
        r = 1'b0;
        case (cond)
            COND_ALWAYS: r = 1'b1;
            COND_Z:      r = z;
            COND_NZ:     r = ~z;
            COND_C:      r = c;
            COND_NC:     r = ~c;
            COND_N:      r = n;
            COND_NN:     r = ~n;
            COND_P:      r = p;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jump_controller_return_stack.sv
// LIFO of return addresses for call/return; only built when JUMP_CTRL_CALL_EN is defined.
`ifdef JUMP_CTRL_CALL_EN
module return_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q & ~push_i;

    // Top-of-stack is kept in its own register so data_o is a flop output.
    always_comb begin
        sp_d  = sp_q;
        top_d = top_q;
        if (do_push) begin
            sp_d  = sp_q + PTR_W'(1);
            top_d = data_i;
        end else if (do_pop) begin
            sp_d  = sp_q - PTR_W'(1);
            top_d = (sp_q > PTR_W'(1)) ? mem_q[IDX_W'(sp_q - PTR_W'(2))] : '0;
        end
        full_d  = (sp_d == PTR_W'(DEPTH));
        empty_d = (sp_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= '0;
            top_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            sp_q    <= sp_d;
            top_q   <= top_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[IDX_W'(sp_q)] <= data_i;
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign data_o  = top_q;

endmodule
`endif

// File: rtl/jump_controller.sv
// Program-counter sequencer with conditional jumps (fixed two-edge latency).
// Define JUMP_CTRL_CALL_EN to add call/ret through a return stack and the stk_err pulse.
module jump_controller
    import jump_controller_pkg::*;
#(
    parameter int unsigned MAX_WIDTH   = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 C,
    input  logic                 N,
    input  logic                 Z,
    input  logic                 P,
    input  logic                 step,
    input  logic                 jreq,
    input  logic [COND_W-1:0]    jcond,
    input  logic [MAX_WIDTH-1:0] jtarget,
`ifdef JUMP_CTRL_CALL_EN
    input  logic                 call,
    input  logic                 ret,
    output logic                 stk_err,
`endif
    output logic [MAX_WIDTH-1:0] pc,
    output logic                 jack,
    output logic                 taken,
    output logic                 busy
);

    state_e                state_q, state_d;
    logic [MAX_WIDTH-1:0]  pc_q, pc_d, pc_inc;
    logic [MAX_WIDTH-1:0]  target_q, target_d;
    logic [COND_W-1:0]     cond_q, cond_d;
    logic                  taken_q, taken_d;
    logic                  jack_q, jack_d;
    logic                  busy_q, busy_d;

`ifdef JUMP_CTRL_CALL_EN
    logic                  call_q, call_d;
    logic                  err_q, err_d;
    logic                  push, pop;
    logic                  stk_full, stk_empty;
    logic [MAX_WIDTH-1:0]  stk_top;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (MAX_WIDTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .data_o  (stk_top)
    );
`endif

    assign pc_inc = pc_q + MAX_WIDTH'(1);

    // Next-state and datapath decisions.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        cond_d   = cond_q;
        taken_d  = taken_q;
`ifdef JUMP_CTRL_CALL_EN
        call_d   = call_q;
        err_d    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (jreq) begin
                    cond_d   = jcond;
                    target_d = jtarget;
`ifdef JUMP_CTRL_CALL_EN
                    call_d   = call;
`endif
                    state_d  = EVAL;
`ifdef JUMP_CTRL_CALL_EN
                end else if (ret) begin
                    if (stk_empty) begin
                        taken_d = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        pc_d    = stk_top;
                        taken_d = 1'b1;
                        pop     = 1'b1;
                    end
                    state_d = DONE;
`endif
                end else if (step) begin
                    pc_d = pc_inc;
                end
            end
            EVAL: begin
                if (cond_met(cond_q, C, N, Z, P)) begin
`ifdef JUMP_CTRL_CALL_EN
                    // A call with no room leaves pc untouched and reports the overflow.
                    if (call_q && stk_full) begin
                        taken_d = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        pc_d    = target_q;
                        taken_d = 1'b1;
                        push    = call_q;
                    end
`else
                    pc_d    = target_q;
                    taken_d = 1'b1;
`endif
                end else begin
                    pc_d    = pc_inc;
                    taken_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        jack_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            target_q <= '0;
            cond_q   <= '0;
            taken_q  <= 1'b0;
            jack_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            cond_q   <= cond_d;
            taken_q  <= taken_d;
            jack_q   <= jack_d;
            busy_q   <= busy_d;
        end
    end

`ifdef JUMP_CTRL_CALL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            call_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            call_q <= call_d;
            err_q  <= err_d;
        end
    end

    assign stk_err = err_q;
`endif

    assign pc    = pc_q;
    assign jack  = jack_q;
    assign taken = taken_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_jump_controller.sv
// Directed self-checking bench for jump_controller; covers call/ret when JUMP_CTRL_CALL_EN is defined.
module tb_jump_controller;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst, C, N, Z, P, step, jreq;
    logic [2:0]   jcond;
    logic [W-1:0] jtarget;
    logic [W-1:0] pc;
    logic         jack, taken, busy;
`ifdef JUMP_CTRL_CALL_EN
    logic         call, ret, stk_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    jump_controller #(.MAX_WIDTH(W), .STACK_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .C       (C),
        .N       (N),
        .Z       (Z),
        .P       (P),
        .step    (step),
        .jreq    (jreq),
        .jcond   (jcond),
        .jtarget (jtarget),
`ifdef JUMP_CTRL_CALL_EN
        .call    (call),
        .ret     (ret),
        .stk_err (stk_err),
`endif
        .pc      (pc),
        .jack    (jack),
        .taken   (taken),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input logic [2:0] cond, input logic [W-1:0] tgt);
        jreq = 1'b1; jcond = cond; jtarget = tgt;
        tick();
        jreq = 1'b0;
    endtask

    // Hand-computed condition table: flags {C,N,Z,P}, target, expected taken.
    logic [2:0]   tbl_cond  [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [3:0]   tbl_flags [6] = '{4'b0000, 4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0001};
    logic         tbl_taken [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [W-1:0] exp_pc;
        rst = 1'b1; C = 0; N = 0; Z = 0; P = 0; step = 0; jreq = 0;
        jcond = '0; jtarget = '0;
`ifdef JUMP_CTRL_CALL_EN
        call = 0; ret = 0;
`endif
        #1;
        tick();
        check_eq("reset_pc", 32'(pc), 32'h0);
        check_eq("reset_taken", 32'(taken), 32'h0);
        check_eq("reset_jack", 32'(jack), 32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);

        // Step to 5, then reset overrides step, then step three times.
        rst = 1'b0; step = 1'b1;
        repeat (5) tick();
        check_eq("step_to_5", 32'(pc), 32'h05);
        rst = 1'b1;
        tick();
        check_eq("reset_over_step", 32'(pc), 32'h00);
        rst = 1'b0;
        repeat (3) tick();
        step = 1'b0;
        check_eq("step3_pc", 32'(pc), 32'h03);
        check_eq("step3_taken", 32'(taken), 32'h0);
        check_eq("step3_jack", 32'(jack), 32'h0);

        // Unconditional jump to 0xFF, latency check, then wrap on step.
        do_jump(3'b000, 8'hFF);
        check_eq("eval_busy", 32'(busy), 32'h1);
        check_eq("eval_jack", 32'(jack), 32'h0);
        check_eq("eval_pc_held", 32'(pc), 32'h03);
        tick();
        check_eq("always_pc", 32'(pc), 32'hFF);
        check_eq("always_taken", 32'(taken), 32'h1);
        check_eq("done_jack", 32'(jack), 32'h1);
        check_eq("done_busy", 32'(busy), 32'h1);
        tick();
        check_eq("jack_one_cycle", 32'(jack), 32'h0);
        check_eq("idle_busy", 32'(busy), 32'h0);
        step = 1'b1;
        tick();
        step = 1'b0;
        check_eq("wrap_pc", 32'(pc), 32'h00);
        check_eq("taken_holds", 32'(taken), 32'h1);

        // Jump-if-Z with Z=1 then Z=0.
        Z = 1'b1;
        do_jump(3'b001, 8'h40);
        tick();
        check_eq("jz_taken_pc", 32'(pc), 32'h40);
        check_eq("jz_taken", 32'(taken), 32'h1);
        check_eq("jz_jack", 32'(jack), 32'h1);
        tick();
        check_eq("jz_jack_off", 32'(jack), 32'h0);
        Z = 1'b0;
        do_jump(3'b001, 8'h60);
        tick();
        check_eq("jz_not_pc", 32'(pc), 32'h41);
        check_eq("jz_not_taken", 32'(taken), 32'h0);
        tick();

        // Flags are sampled at the evaluating edge, not at the request.
        Z = 1'b1;
        do_jump(3'b001, 8'h70);
        Z = 1'b0;
        tick();
        check_eq("late_flag_pc", 32'(pc), 32'h42);
        check_eq("late_flag_taken", 32'(taken), 32'h0);
        tick();

        // Remaining condition codes.
        exp_pc = 8'h42;
        for (int i = 0; i < 6; i++) begin
            {C, N, Z, P} = tbl_flags[i];
            do_jump(tbl_cond[i], W'(8'h10 + i));
            tick();
            exp_pc = tbl_taken[i] ? W'(8'h10 + i) : exp_pc + 8'h01;
            check_eq($sformatf("cond%0d_pc", i), 32'(pc), 32'(exp_pc));
            check_eq($sformatf("cond%0d_taken", i), 32'(taken), 32'(tbl_taken[i]));
            tick();
        end
        {C, N, Z, P} = 4'b0000;

        // jreq+step together, then more requests while busy.
        jreq = 1'b1; step = 1'b1; jcond = 3'b000; jtarget = 8'h80;
        tick();
        jtarget = 8'h90;
        check_eq("prio_eval_pc", 32'(pc), 32'(exp_pc));
        tick();
        check_eq("prio_pc", 32'(pc), 32'h80);
        check_eq("prio_jack", 32'(jack), 32'h1);
        tick();
        jreq = 1'b0; step = 1'b0;
        check_eq("busy_ignored_pc", 32'(pc), 32'h80);
        check_eq("busy_ignored_busy", 32'(busy), 32'h0);
        check_eq("busy_ignored_jack", 32'(jack), 32'h0);
        tick();
        check_eq("single_jump_pc", 32'(pc), 32'h80);
        check_eq("single_jump_jack", 32'(jack), 32'h0);

        // Reset during EVAL aborts with no jack.
        do_jump(3'b000, 8'hAA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_pc", 32'(pc), 32'h00);
        check_eq("abort_busy", 32'(busy), 32'h0);
        check_eq("abort_taken", 32'(taken), 32'h0);
        tick();
        check_eq("abort_no_jack", 32'(jack), 32'h0);
        check_eq("abort_pc_stays", 32'(pc), 32'h00);

`ifdef JUMP_CTRL_CALL_EN
        // DEPTH+1 calls: pushes 0x01,0x21,0x22,0x23, the last call overflows.
        call = 1'b1;
        for (int i = 0; i <= int'(DEPTH); i++) begin
            do_jump(3'b000, W'(8'h20 + i));
            tick();
            if (i < int'(DEPTH)) begin
                check_eq($sformatf("call%0d_pc", i), 32'(pc), 32'(8'h20 + i));
                check_eq($sformatf("call%0d_err", i), 32'(stk_err), 32'h0);
            end else begin
                check_eq("call_ovf_pc", 32'(pc), 32'h23);
                check_eq("call_ovf_taken", 32'(taken), 32'h0);
                check_eq("call_ovf_err", 32'(stk_err), 32'h1);
            end
            tick();
        end
        call = 1'b0;
        check_eq("err_one_cycle", 32'(stk_err), 32'h0);
        exp_pc = 8'h23;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ret = 1'b1;
            tick();
            ret = 1'b0;
            check_eq($sformatf("ret%0d_pc", i), 32'(pc), 32'(exp_pc));
            check_eq($sformatf("ret%0d_taken", i), 32'(taken), 32'h1);
            check_eq($sformatf("ret%0d_jack", i), 32'(jack), 32'h1);
            tick();
            exp_pc = (i == 2) ? 8'h01 : exp_pc - 8'h01;
        end
        ret = 1'b1;
        tick();
        ret = 1'b0;
        check_eq("ret_empty_pc", 32'(pc), 32'h01);
        check_eq("ret_empty_err", 32'(stk_err), 32'h1);
        check_eq("ret_empty_taken", 32'(taken), 32'h0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
